// File: rtl/tiny_dds_pkg.sv
// Shared definitions for the DDS waveform core: datapath widths, waveform
// mode encodings and the phase-dither LFSR constants (used only when the
// PHASE_DITHER_EN macro is defined).
package tiny_dds_pkg;

    localparam int ACC_W   = 28;
    localparam int PHASE_W = 12;
    localparam int OUT_W   = 8;

    typedef enum logic [1:0] {
        MODE_SINE   = 2'd0,
        MODE_TRI    = 2'd1,
        MODE_SQUARE = 2'd2,
        MODE_SAW    = 2'd3
    } mode_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_POLY = 16'hB400;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : 16'h0000);
    endfunction

    // The shaped waveform is symmetric, so -128 is folded onto -127.
    function automatic logic signed [7:0] clamp_neg127(input logic signed [7:0] v);
        return (v == 8'sh80) ? -8'sd127 : v;
    endfunction

endpackage

// File: rtl/dds_sine_quarter_lut.sv
// Quarter-wave sine magnitude ROM: mag = round(127*sin((i+0.5)*pi/128)).
// The half-LSB phase offset makes the mirrored quadrants line up exactly.
module dds_sine_quarter_lut (
    input  logic [5:0] addr_i,
    output logic [6:0] mag_o
);

    // Constant table decoded combinationally.
    // NOTE: a ROM has no state, so there is nothing to reset here.
    always_comb begin
        mag_o = 7'd0;
        case (addr_i)
            6'd0:  mag_o = 7'd2;   6'd1:  mag_o = 7'd5;   6'd2:  mag_o = 7'd8;   6'd3:  mag_o = 7'd11;
            6'd4:  mag_o = 7'd14;  6'd5:  mag_o = 7'd17;  6'd6:  mag_o = 7'd20;  6'd7:  mag_o = 7'd23;
            6'd8:  mag_o = 7'd26;  6'd9:  mag_o = 7'd29;  6'd10: mag_o = 7'd32;  6'd11: mag_o = 7'd35;
            6'd12: mag_o = 7'd38;  6'd13: mag_o = 7'd41;  6'd14: mag_o = 7'd44;  6'd15: mag_o = 7'd47;
            6'd16: mag_o = 7'd50;  6'd17: mag_o = 7'd53;  6'd18: mag_o = 7'd56;  6'd19: mag_o = 7'd58;
            6'd20: mag_o = 7'd61;  6'd21: mag_o = 7'd64;  6'd22: mag_o = 7'd67;  6'd23: mag_o = 7'd69;
            6'd24: mag_o = 7'd72;  6'd25: mag_o = 7'd74;  6'd26: mag_o = 7'd77;  6'd27: mag_o = 7'd79;
            6'd28: mag_o = 7'd82;  6'd29: mag_o = 7'd84;  6'd30: mag_o = 7'd86;  6'd31: mag_o = 7'd89;
            6'd32: mag_o = 7'd91;  6'd33: mag_o = 7'd93;  6'd34: mag_o = 7'd95;  6'd35: mag_o = 7'd97;
            6'd36: mag_o = 7'd99;  6'd37: mag_o = 7'd101; 6'd38: mag_o = 7'd103; 6'd39: mag_o = 7'd105;
            6'd40: mag_o = 7'd106; 6'd41: mag_o = 7'd108; 6'd42: mag_o = 7'd110; 6'd43: mag_o = 7'd111;
            6'd44: mag_o = 7'd113; 6'd45: mag_o = 7'd114; 6'd46: mag_o = 7'd115; 6'd47: mag_o = 7'd117;
            6'd48: mag_o = 7'd118; 6'd49: mag_o = 7'd119; 6'd50: mag_o = 7'd120; 6'd51: mag_o = 7'd121;
            6'd52: mag_o = 7'd122; 6'd53: mag_o = 7'd123; 6'd54: mag_o = 7'd124; 6'd55: mag_o = 7'd124;
            6'd56: mag_o = 7'd125; 6'd57: mag_o = 7'd125; 6'd58: mag_o = 7'd126; 6'd59: mag_o = 7'd126;
            6'd60: mag_o = 7'd127; 6'd61: mag_o = 7'd127; 6'd62: mag_o = 7'd127; 6'd63: mag_o = 7'd127;
            default: mag_o = 7'd0;
        endcase
    end

endmodule

// File: rtl/dds_waveform_core.sv
// DDS waveform core: phase accumulator -> phase offset -> waveform shaping
// -> gain -> DC offset with saturation, producing an unsigned 8-bit DAC code.
// One pipeline register per stage, 4 clocks from accumulator to output.
// Define PHASE_DITHER_EN to add LFSR dither below the truncated phase bits.
module dds_waveform_core
    import tiny_dds_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               phase_clear,
    input  logic               fsel,
    input  logic               psel,
    input  logic [ACC_W-1:0]   freq0,
    input  logic [ACC_W-1:0]   freq1,
    input  logic [PHASE_W-1:0] phase0,
    input  logic [PHASE_W-1:0] phase1,
    input  logic [1:0]         mode,
    input  logic [7:0]         gain,
    input  logic [7:0]         offset,
    output logic [OUT_W-1:0]   sample_out,
    output logic               sample_valid
);

    logic [ACC_W-1:0]   acc_q,    acc_d;
    logic [PHASE_W-1:0] phase_q,  phase_d;
    logic signed [7:0]  wave_q,   wave_d;
    logic signed [7:0]  scaled_q, scaled_d;
    logic [OUT_W-1:0]   sample_q, sample_d;
    logic [3:0]         valid_q,  valid_d;

    logic [PHASE_W-1:0] phase_src;
    logic [5:0]         lut_addr;
    logic [6:0]         lut_mag;
    logic signed [7:0]  sine_mag;
    logic [7:0]         tri_t;
    logic signed [15:0] product;
    logic signed [9:0]  sum;

    // S0: accumulator next state; clear beats enable, wrap is modulo 2^ACC_W.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        acc_d = acc_q;
        if (phase_clear) begin
            acc_d = '0;
        end else if (enable) begin
            acc_d = acc_q + (fsel ? freq1 : freq0);
        end
    end

`ifdef PHASE_DITHER_EN
    logic [15:0] lfsr_q;

    // Free-running dither source, restarted from the seed on reset.
    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= LFSR_SEED;
        else     lfsr_q <= lfsr_step(lfsr_q);
    end

    assign phase_src = PHASE_W'((acc_q + {{(ACC_W-16){1'b0}}, lfsr_q}) >> (ACC_W - PHASE_W));
`else
    assign phase_src = acc_q[ACC_W-1 -: PHASE_W];
`endif

    // S1: truncated phase plus the selected phase offset, modulo 2^PHASE_W.
    assign phase_d = phase_src + (psel ? phase1 : phase0);

    // S2: quarter-wave sine lookup, mirrored in odd quadrants, negated in the lower half.
    assign lut_addr = phase_q[10] ? ~phase_q[9:4] : phase_q[9:4];
    assign sine_mag = signed'({1'b0, lut_mag});
    assign tri_t    = phase_q[11] ? ~phase_q[10:3] : phase_q[10:3];

    dds_sine_quarter_lut u_sine_lut (
        .addr_i (lut_addr),
        .mag_o  (lut_mag)
    );

    // S2: waveform shaping into a symmetric signed sample (-127..+127).
    always_comb begin
        wave_d = '0;
        case (mode_e'(mode))
            MODE_SINE:   wave_d = phase_q[11] ? -sine_mag : sine_mag;
            MODE_TRI:    wave_d = clamp_neg127({~tri_t[7], tri_t[6:0]});
            MODE_SQUARE: wave_d = phase_q[11] ? -8'sd127 : 8'sd127;
            MODE_SAW:    wave_d = clamp_neg127({~phase_q[11], phase_q[10:4]});
            default:     wave_d = '0;
        endcase
    end

    // S3: amplitude scale; arithmetic shift floors negative products.
    assign product  = 16'(wave_q) * 16'($signed({1'b0, gain}));
    assign scaled_d = 8'(product >>> 8);

    // S4: DC offset, midscale shift and saturation to the unsigned DAC range.
    assign sum      = 10'(scaled_q) + 10'($signed(offset)) + 10'sd128;
    assign sample_d = sum[9] ? 8'd0 : (sum[8] ? 8'd255 : sum[7:0]);

    // Valid marker travels alongside the first post-reset data.
    assign valid_d  = {valid_q[2:0], 1'b1};

    // Pipeline registers with synchronous reset; the output idles at midscale.
    // NOTE: sequential state uses non-blocking assignments so all stages update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            phase_q  <= '0;
            wave_q   <= '0;
            scaled_q <= '0;
            sample_q <= 8'd128;
            valid_q  <= '0;
        end else begin
            acc_q    <= acc_d;
            phase_q  <= phase_d;
            wave_q   <= wave_d;
            scaled_q <= scaled_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
        end
    end

    assign sample_out   = sample_q;
    assign sample_valid = valid_q[3];

endmodule
